// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM states,
// and the request legality rule applied at acceptance.
// Contents: F3_* funct3 constants, lsu_state_e, access_legal().
package lsu_pkg;

  // RV32I load/store width codes (funct3)
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_WAIT  = 3'd2,
    WR_ISSUE = 3'd3,
    RESP     = 3'd4
  } lsu_state_e;

  // Alignment plus width-code check. Unsigned widths only make sense for loads.
  function automatic logic access_legal(input logic we, input logic [2:0] f3,
                                        input logic [1:0] off);
    logic ok;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~off[0];
      F3_W:    ok = (off == 2'b00);
      F3_BU:   ok = ~we;
      F3_HU:   ok = ~we & ~off[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_store_unit_lane.sv
// Purpose: lane extract + sign/zero extend for loads, lane merge for sub-word stores.
// Latency: combinational. Backpressure: none.
// Ports: funct3/byte_off select the lane; rd_word is the memory word, wdata the
//        store data; load_data is the extended load result, merged_word the
//        read-modify-write result (wdata itself for word width).
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] rd_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rd_word[{byte_off, 3'b000} +: 8];
    // Half accesses are always half-aligned, so only byte_off[1] picks the lane.
    half_v = byte_off[1] ? rd_word[31:16] : rd_word[15:0];

    case (funct3)
      F3_B:    load_data = {{24{byte_v[7]}}, byte_v};
      F3_BU:   load_data = {24'd0, byte_v};
      F3_H:    load_data = {{16{half_v[15]}}, half_v};
      F3_HU:   load_data = {16'd0, half_v};
      default: load_data = rd_word;
    endcase

    merged_word = rd_word;
    case (funct3)
      F3_B:    merged_word[{byte_off, 3'b000} +: 8] = wdata[7:0];
      F3_H:    merged_word[{byte_off[1], 4'b0000} +: 16] = wdata[15:0];
      default: merged_word = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Purpose: single-outstanding RV32I load/store unit in front of a 1-cycle data memory.
// Latency: accept to resp_valid cycle: illegal 1, word store 2, load 3, sub-word store 4.
// Backpressure: req_ready only in IDLE; the response is a one-cycle pulse, never stalled.
// Ports: req_* request (valid/ready), resp_* completion, mem_* data-memory port.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDRW = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout
);

  lsu_state_e        state_q, state_d;
  logic [ADDRW-1:0]  addr_q, addr_d;
  logic              we_q, we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [31:0]       data_q, data_d;   // store data, then merged word or load result
  logic              err_q, err_d;

  logic [31:0]       load_data, merged_word, word_addr;
  logic              req_legal;
  logic              unused_addr_hi;

  // Only the low ADDRW address bits reach memory.
  assign unused_addr_hi = ^req_addr;
  assign req_legal      = access_legal(req_we, req_funct3, req_addr[1:0]);

  lsu_lane u_lane (
    .funct3      (funct3_q),
    .byte_off    (addr_q[1:0]),
    .rd_word     (mem_dout),
    .wdata       (data_q),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      funct3_q <= 3'd0;
      data_q   <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      data_q   <= data_d;
      err_q    <= err_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (!req_legal)                         state_d = RESP;
          else if (req_we && req_funct3 == F3_W)  state_d = WR_ISSUE;
          else                                    state_d = RD_ISSUE;
        end
      end
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT:  state_d = we_q ? WR_ISSUE : RESP;
      WR_ISSUE: state_d = RESP;
      RESP:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    addr_d   = addr_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    data_d   = data_q;
    err_d    = err_q;
    if (state_q == IDLE && req_valid) begin
      addr_d   = req_addr[ADDRW-1:0];
      we_d     = req_we;
      funct3_d = req_funct3;
      data_d   = req_wdata;
      err_d    = ~req_legal;
    end else if (state_q == RD_WAIT) begin
      // mem_dout is valid this cycle: keep either the merged store word or the load result.
      data_d = we_q ? merged_word : load_data;
    end
  end

  // Outputs
  always_comb begin
    word_addr = 32'd0;
    word_addr[ADDRW-1:2] = addr_q[ADDRW-1:2];

    req_ready  = (state_q == IDLE);
    mem_we     = (state_q == WR_ISSUE);
    mem_addr   = 32'd0;
    mem_din    = 32'd0;
    resp_valid = (state_q == RESP);
    resp_err   = 1'b0;
    resp_rdata = 32'd0;
    if (state_q == RD_ISSUE || state_q == WR_ISSUE) mem_addr = word_addr;
    if (state_q == WR_ISSUE)                        mem_din  = data_q;
    if (state_q == RESP) begin
      resp_err = err_q;
      if (!we_q && !err_q) resp_rdata = data_q;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_din, mem_dout;

  always #5 clk = ~clk;

  load_store_unit #(.ADDRW(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // Data memory: capture at edge N, read data valid until N+1, write commits at N+1.
  logic [31:0] mem [0:63];
  logic [5:0]  cap_idx;
  logic        pend_we;
  logic [31:0] pend_din;
  logic        init_mem;

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'd0;
      mem[6'h04] <= 32'h8899AABB;  // 0x10
      mem[6'h08] <= 32'h11223344;  // 0x20
      mem[6'h0C] <= 32'hCAFEF00D;  // 0x30
    end else if (pend_we === 1'b1) begin
      mem[cap_idx] <= pend_din;
    end
    cap_idx  <= mem_addr[7:2];
    pend_we  <= mem_we;
    pend_din <= mem_din;
  end
  assign mem_dout = mem[cap_idx];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec  = 0;
  int n_miss = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
    string       nm;
  } resp_t;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] din;
    string       nm;
  } wr_t;

  resp_t resp_q[$];
  wr_t   wr_q[$];

  // Monitor: compares whatever the DUT presents against the scoreboard queues.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (resp_valid === 1'b1) begin
        if (resp_q.size() == 0) begin
          chk("unexpected_resp", 32'd1, 32'd0);
        end else begin
          resp_t e;
          e = resp_q.pop_front();
          chk({e.nm, ".rdata"}, resp_rdata, e.rdata);
          chk({e.nm, ".err"}, {31'd0, resp_err}, {31'd0, e.err});
          chk({e.nm, ".latency"}, cyc - e.acc + 1, e.lat);
        end
      end
      if (mem_we === 1'b1) begin
        if (wr_q.size() == 0) begin
          chk("unexpected_mem_we", 32'd1, 32'd0);
        end else begin
          wr_t w;
          w = wr_q.pop_front();
          chk({w.nm, ".mem_addr"}, mem_addr, w.addr);
          chk({w.nm, ".mem_din"}, mem_din, w.din);
        end
      end
      if (req_ready === 1'b1) begin
        chk("idle.mem_addr_din", mem_addr | mem_din, 32'd0);
      end
    end
  end

  task automatic issue(input string nm, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] erd, input logic eerr, input int elat,
                       input logic push_resp, input logic ewr,
                       input logic [31:0] waddr, input logic [31:0] wdin);
    int t;
    t = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      chk({nm, ".accept_timeout"}, 32'd1, 32'd0);
    end else begin
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;
      if (push_resp) resp_q.push_back('{rdata: erd, err: eerr, lat: elat, acc: cyc + 1, nm: nm});
      if (ewr)       wr_q.push_back('{addr: waddr, din: wdin, nm: nm});
      @(negedge clk);
      // Junk on the request bus while busy must be ignored.
      req_valid  = 1'b0;
      req_we     = 1'b1;
      req_funct3 = 3'd2;
      req_addr   = 32'hFFFF_FFFC;
      req_wdata  = 32'hDEAD_DEAD;
    end
  endtask

  initial begin
    int t;
    rst = 1'b1;
    init_mem = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_funct3 = 3'd0;
    req_addr = 32'd0;
    req_wdata = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst.req_ready",  {31'd0, req_ready},  32'd1);
    chk("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst.resp_err",   {31'd0, resp_err},   32'd0);
    chk("rst.resp_rdata", resp_rdata,           32'd0);
    chk("rst.mem_we",     {31'd0, mem_we},     32'd0);
    chk("rst.mem_addr",   mem_addr,             32'd0);
    chk("rst.mem_din",    mem_din,              32'd0);
    init_mem = 1'b0;
    rst = 1'b0;

    // Loads from word 0x8899AABB @0x10
    issue("lw_10",  1'b0, 3'd2, 32'h10, 32'h0, 32'h8899AABB, 1'b0, 3, 1'b1, 1'b0, 32'h0, 32'h0);
    issue("lb_13",  1'b0, 3'd0, 32'h13, 32'h0, 32'hFFFFFF88, 1'b0, 3, 1'b1, 1'b0, 32'h0, 32'h0);
    issue("lbu_13", 1'b0, 3'd4, 32'h13, 32'h0, 32'h00000088, 1'b0, 3, 1'b1, 1'b0, 32'h0, 32'h0);
    issue("lh_12",  1'b0, 3'd1, 32'h12, 32'h0, 32'hFFFF8899, 1'b0, 3, 1'b1, 1'b0, 32'h0, 32'h0);
    issue("lhu_10", 1'b0, 3'd5, 32'h10, 32'h0, 32'h0000AABB, 1'b0, 3, 1'b1, 1'b0, 32'h0, 32'h0);
    issue("lb_11",  1'b0, 3'd0, 32'h11, 32'h0, 32'hFFFFFFAA, 1'b0, 3, 1'b1, 1'b0, 32'h0, 32'h0);
    issue("lw_hiaddr", 1'b0, 3'd2, 32'hFFFF_FF10, 32'h0, 32'h8899AABB, 1'b0, 3, 1'b1, 1'b0, 32'h0, 32'h0);

    // Sub-word stores into 0x11223344 @0x20, each followed by a read-back
    issue("sb_21", 1'b1, 3'd0, 32'h21, 32'h000000AB, 32'h0, 1'b0, 4, 1'b1, 1'b1, 32'h20, 32'h1122AB44);
    issue("lw_20a", 1'b0, 3'd2, 32'h20, 32'h0, 32'h1122AB44, 1'b0, 3, 1'b1, 1'b0, 32'h0, 32'h0);
    issue("sh_22", 1'b1, 3'd1, 32'h22, 32'hDEADBEEF, 32'h0, 1'b0, 4, 1'b1, 1'b1, 32'h20, 32'hBEEFAB44);
    issue("lw_20b", 1'b0, 3'd2, 32'h20, 32'h0, 32'hBEEFAB44, 1'b0, 3, 1'b1, 1'b0, 32'h0, 32'h0);

    // Word store then read-back
    issue("sw_24", 1'b1, 3'd2, 32'h24, 32'h01020304, 32'h0, 1'b0, 2, 1'b1, 1'b1, 32'h24, 32'h01020304);
    issue("lw_24", 1'b0, 3'd2, 32'h24, 32'h0, 32'h01020304, 1'b0, 3, 1'b1, 1'b0, 32'h0, 32'h0);

    // Illegal requests: no memory access, err with zero data after one cycle
    issue("lw_22_mis",  1'b0, 3'd2, 32'h22, 32'h0, 32'h0, 1'b1, 1, 1'b1, 1'b0, 32'h0, 32'h0);
    issue("sh_23_mis",  1'b1, 3'd1, 32'h23, 32'h1234, 32'h0, 1'b1, 1, 1'b1, 1'b0, 32'h0, 32'h0);
    issue("sbu_ill",    1'b1, 3'd4, 32'h20, 32'h55, 32'h0, 1'b1, 1, 1'b1, 1'b0, 32'h0, 32'h0);
    issue("ld_f3_3",    1'b0, 3'd3, 32'h20, 32'h0, 32'h0, 1'b1, 1, 1'b1, 1'b0, 32'h0, 32'h0);
    issue("sw_11_mis",  1'b1, 3'd2, 32'h11, 32'h77, 32'h0, 1'b1, 1, 1'b1, 1'b0, 32'h0, 32'h0);

    // Reset during RD_WAIT of a sub-word store: no write, no response
    issue("sb_30_abort", 1'b1, 3'd0, 32'h30, 32'h99, 32'h0, 1'b0, 0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);  // now in RD_WAIT
    rst = 1'b1;
    @(negedge clk);
    chk("abort.req_ready",  {31'd0, req_ready},  32'd1);
    chk("abort.resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("abort.mem_we",     {31'd0, mem_we},     32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    issue("lw_30", 1'b0, 3'd2, 32'h30, 32'h0, 32'hCAFEF00D, 1'b0, 3, 1'b1, 1'b0, 32'h0, 32'h0);

    t = 0;
    while (resp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    chk("drain.resp_q", resp_q.size(), 32'd0);
    chk("drain.wr_q",   wr_q.size(),   32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
